// File: rtl/multi_dataflow_job_sequencer.sv
// multi_dataflow_job_sequencer: runs streamers and engine through every iteration of a job.
// Define MDF_SEQ_WATCHDOG_EN to add a no-progress watchdog that aborts the job in COMPUTE.
module multi_dataflow_job_sequencer #(
    parameter int ITER_W  = 16,
    parameter int LEN_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              trigger_i,
    input  logic [ITER_W-1:0] n_iter_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              src_start_o,
    output logic              sink_start_o,
    input  logic              src_done_i,
    input  logic              sink_done_i,
    output logic              eng_start_o,
    output logic              eng_clear_o,
    input  logic              eng_ready_i,
    input  logic [LEN_W-1:0]  out_cnt_i,
    input  logic              out_hs_i,
    output logic              busy_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              evt_o,
    output logic              err_o
);
    typedef enum logic [2:0] {IDLE, START_STR, START_ENG, COMPUTE, NEXT, DONE} state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] n_iter_q, iter_q;
    logic [LEN_W-1:0]  len_q;
    logic              src_f, sink_f, both, last, accept, timeout, abort_q, collect;

    assign accept  = state_q == IDLE && trigger_i;
    assign collect = state_q == START_ENG || state_q == COMPUTE;
    assign both    = (src_f | src_done_i) & (sink_f | sink_done_i);
    // a zero-iteration job passes through NEXT only to give busy_o its one cycle
    assign last    = n_iter_q == '0 || iter_q == n_iter_q - ITER_W'(1);
    assign iter_o  = iter_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (trigger_i) state_d = n_iter_i == '0 ? NEXT : START_STR;
            START_STR: state_d = START_ENG;
            START_ENG: if (eng_ready_i) state_d = COMPUTE;
            COMPUTE:   if (both || timeout) state_d = NEXT;
            NEXT:      state_d = last || abort_q ? DONE : START_STR;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            n_iter_q     <= '0;
            iter_q       <= '0;
            len_q        <= '0;
            src_f        <= 1'b0;
            sink_f       <= 1'b0;
            src_start_o  <= 1'b0;
            sink_start_o <= 1'b0;
            eng_start_o  <= 1'b0;
            eng_clear_o  <= 1'b0;
            busy_o       <= 1'b0;
            evt_o        <= 1'b0;
            err_o        <= 1'b0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            n_iter_q     <= '0;
            iter_q       <= '0;
            len_q        <= '0;
            src_f        <= 1'b0;
            sink_f       <= 1'b0;
            src_start_o  <= 1'b0;
            sink_start_o <= 1'b0;
            eng_start_o  <= 1'b0;
            eng_clear_o  <= 1'b0;
            busy_o       <= 1'b0;
            evt_o        <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                n_iter_q <= n_iter_i;
                len_q    <= len_i;
                iter_q   <= '0;
            end else if (state_q == NEXT && state_d == START_STR) begin
                iter_q <= iter_q + ITER_W'(1);
            end
            src_f        <= collect & (src_f | src_done_i);
            sink_f       <= collect & (sink_f | sink_done_i);
            src_start_o  <= state_d == START_STR;
            sink_start_o <= state_d == START_STR;
            eng_start_o  <= state_q == START_ENG && state_d == COMPUTE;
            eng_clear_o  <= state_q == COMPUTE && state_d == NEXT;
            busy_o       <= state_d != IDLE && state_d != DONE;
            evt_o        <= state_d == DONE;
            if (accept)
                err_o <= 1'b0;
            else if (state_q == COMPUTE && (timeout || (both && out_cnt_i < len_q)))
                err_o <= 1'b1;
        end
    end

`ifdef MDF_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;

    assign timeout = state_q == COMPUTE && !out_hs_i && wd_q == WD_W'(TIMEOUT - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else if (clear_i) begin
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            wd_q    <= state_q == COMPUTE && state_d == COMPUTE && !out_hs_i ? wd_q + WD_W'(1) : '0;
            abort_q <= accept ? 1'b0 : abort_q | timeout;
        end
    end
`else
    logic unused_wd;
    assign timeout   = 1'b0;
    assign abort_q   = 1'b0;
    assign unused_wd = out_hs_i ^ (TIMEOUT == 0);
`endif
endmodule

// File: tb/tb_multi_dataflow_job_sequencer.sv
// tb_multi_dataflow_job_sequencer: directed scenarios for the job sequencer.
module tb_multi_dataflow_job_sequencer;
`ifdef MDF_SEQ_WATCHDOG_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif
    logic        clk = 0, rst_ni = 0, clear = 0, trigger = 0;
    logic [15:0] n_iter = 0;
    logic [31:0] len = 0, out_cnt = 0;
    logic        src_done = 0, sink_done = 0, eng_ready = 1, out_hs = 0;
    logic        src_start, sink_start, eng_start, eng_clear, busy, evt, err;
    logic [15:0] iter;

    int checks = 0, errors = 0;
    int cnt_src = 0, cnt_sink = 0, cnt_es = 0, cnt_ec = 0, cnt_evt = 0, busy_gaps = 0;
    int b_src, b_sink, b_es, b_ec, b_evt;
    logic [15:0] iter_log[$];
    bit job_active = 0;

    multi_dataflow_job_sequencer #(.ITER_W(16), .LEN_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .trigger_i(trigger),
        .n_iter_i(n_iter), .len_i(len), .src_start_o(src_start), .sink_start_o(sink_start),
        .src_done_i(src_done), .sink_done_i(sink_done), .eng_start_o(eng_start),
        .eng_clear_o(eng_clear), .eng_ready_i(eng_ready), .out_cnt_i(out_cnt),
        .out_hs_i(out_hs), .busy_o(busy), .iter_o(iter), .evt_o(evt), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_ni) begin
        cnt_src  += int'(src_start);
        cnt_sink += int'(sink_start);
        cnt_es   += int'(eng_start);
        cnt_ec   += int'(eng_clear);
        cnt_evt  += int'(evt);
        if (eng_start) iter_log.push_back(iter);
        if (job_active && !busy && !evt) busy_gaps++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_src = cnt_src; b_sink = cnt_sink; b_es = cnt_es; b_ec = cnt_ec; b_evt = cnt_evt;
    endtask

    task automatic trig(input logic [15:0] n, input logic [31:0] l);
        n_iter = n; len = l; trigger = 1;
        cyc(1);
        trigger = 0;
    endtask

    task automatic pulse_dones();
        src_done = 1; sink_done = 1;
        cyc(1);
        src_done = 0; sink_done = 0;
    endtask

    task automatic wait_eng_start(input string name);
        int t = 0;
        while (!eng_start && t < 100) begin cyc(1); t++; end
        checks++;
        if (!eng_start) begin errors++; $display("FAIL %s: eng_start_o not seen in %0d cycles", name, t); end
    endtask

    task automatic serve(input int n, input int dly);
        for (int i = 0; i < n; i++) begin
            wait_eng_start($sformatf("serve_start_%0d", i));
            cyc(dly);
            pulse_dones();
        end
    endtask

    task automatic wait_evt(input string name, output int k);
        k = 0;
        while (!evt && k < 200) begin cyc(1); k++; end
        checks++;
        if (!evt) begin errors++; $display("FAIL %s: evt_o not seen in %0d cycles", name, k); end
    endtask

    task automatic test_reset();
        trigger = 1; n_iter = 1;
        cyc(2);
        checks += 7;
        if (busy !== 0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (evt !== 0)       begin errors++; $display("FAIL reset_evt: got %b want 0", evt); end
        if (err !== 0)       begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        if (iter !== 0)      begin errors++; $display("FAIL reset_iter: got %0d want 0", iter); end
        if (src_start !== 0) begin errors++; $display("FAIL reset_src_start: got %b want 0", src_start); end
        if (eng_start !== 0) begin errors++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
        if (eng_clear !== 0) begin errors++; $display("FAIL reset_eng_clear: got %b want 0", eng_clear); end
        trigger = 0;
        rst_ni = 1;
        cyc(2);
    endtask

    task automatic test_single();
        int k;
        snap(); out_cnt = 4;
        trig(1, 4);
        serve(1, 3);
        wait_evt("single_evt", k);
        cyc(3);
        checks += 6;
        if (cnt_src - b_src != 1)   begin errors++; $display("FAIL single_src_start: got %0d want 1", cnt_src - b_src); end
        if (cnt_sink - b_sink != 1) begin errors++; $display("FAIL single_sink_start: got %0d want 1", cnt_sink - b_sink); end
        if (cnt_es - b_es != 1)     begin errors++; $display("FAIL single_eng_start: got %0d want 1", cnt_es - b_es); end
        if (cnt_ec - b_ec != 1)     begin errors++; $display("FAIL single_eng_clear: got %0d want 1", cnt_ec - b_ec); end
        if (cnt_evt - b_evt != 1)   begin errors++; $display("FAIL single_evt_count: got %0d want 1", cnt_evt - b_evt); end
        if (err !== 0)              begin errors++; $display("FAIL single_err: got %b want 0", err); end
    endtask

    task automatic test_latency();
        int k = 0;
        out_cnt = 4; src_done = 1; sink_done = 1;
        trig(1, 4);
        k = 1;
        while (!evt && k < 50) begin cyc(1); k++; end
        src_done = 0; sink_done = 0;
        checks += 2;
        if (k != 5)   begin errors++; $display("FAIL latency: got %0d cycles want 5", k); end
        if (err !== 0) begin errors++; $display("FAIL latency_err: got %b want 0", err); end
        cyc(2);
    endtask

    task automatic test_zero_iter();
        int k, busy_n;
        snap();
        trig(0, 4);
        k = 1; busy_n = int'(busy);
        while (!evt && k < 50) begin cyc(1); k++; busy_n += int'(busy); end
        cyc(2);
        checks += 4;
        if (k != 2)               begin errors++; $display("FAIL zero_evt_latency: got %0d want 2", k); end
        if (busy_n != 1)          begin errors++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_n); end
        if (cnt_src - b_src != 0) begin errors++; $display("FAIL zero_src_start: got %0d want 0", cnt_src - b_src); end
        if (cnt_es - b_es != 0)   begin errors++; $display("FAIL zero_eng_start: got %0d want 0", cnt_es - b_es); end
    endtask

    task automatic test_multi();
        int k, base;
        snap(); out_cnt = 8; base = iter_log.size(); busy_gaps = 0;
        trig(3, 8);
        job_active = 1;
        serve(3, 2);
        wait_evt("multi_evt", k);
        job_active = 0;
        cyc(3);
        checks += 7;
        if (cnt_src - b_src != 3)   begin errors++; $display("FAIL multi_src_start: got %0d want 3", cnt_src - b_src); end
        if (cnt_es - b_es != 3)     begin errors++; $display("FAIL multi_eng_start: got %0d want 3", cnt_es - b_es); end
        if (cnt_ec - b_ec != 3)     begin errors++; $display("FAIL multi_eng_clear: got %0d want 3", cnt_ec - b_ec); end
        if (cnt_evt - b_evt != 1)   begin errors++; $display("FAIL multi_evt_count: got %0d want 1", cnt_evt - b_evt); end
        if (busy_gaps != 0)         begin errors++; $display("FAIL multi_busy_gaps: got %0d want 0", busy_gaps); end
        if (iter_log.size() - base != 3) begin
            errors++; $display("FAIL multi_iter_count: got %0d want 3", iter_log.size() - base);
        end else if (iter_log[base] !== 0 || iter_log[base+1] !== 1 || iter_log[base+2] !== 2) begin
            errors++; $display("FAIL multi_iter_seq: got %0d,%0d,%0d want 0,1,2", iter_log[base], iter_log[base+1], iter_log[base+2]);
        end
        if (err !== 0)              begin errors++; $display("FAIL multi_err: got %b want 0", err); end
    endtask

    task automatic test_clear_mid_job();
        int k;
        out_cnt = 2;
        trig(3, 8);
        serve(1, 1);
        wait_eng_start("clear_iter1_start");
        checks += 2;
        if (iter !== 1) begin errors++; $display("FAIL clear_pre_iter: got %0d want 1", iter); end
        if (err !== 1)  begin errors++; $display("FAIL short_output_err: got %b want 1", err); end
        clear = 1;
        cyc(1);
        clear = 0;
        checks += 4;
        if (busy !== 0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy); end
        if (iter !== 0) begin errors++; $display("FAIL clear_iter: got %0d want 0", iter); end
        if (err !== 0)  begin errors++; $display("FAIL clear_err: got %b want 0", err); end
        if (evt !== 0)  begin errors++; $display("FAIL clear_evt: got %b want 0", evt); end
        snap();
        cyc(5);
        checks += 2;
        if (cnt_evt - b_evt != 0) begin errors++; $display("FAIL clear_no_evt: got %0d want 0", cnt_evt - b_evt); end
        if (cnt_src - b_src != 0) begin errors++; $display("FAIL clear_no_start: got %0d want 0", cnt_src - b_src); end
        out_cnt = 8;
        trig(1, 8);
        wait_eng_start("restart_start");
        checks++;
        if (iter !== 0) begin errors++; $display("FAIL restart_iter: got %0d want 0", iter); end
        cyc(1);
        pulse_dones();
        wait_evt("restart_evt", k);
        cyc(2);
    endtask

    task automatic test_ready_stall();
        snap(); out_cnt = 4; eng_ready = 0;
        trig(1, 4);
        cyc(3);
        trig(5, 4);
        cyc(2);
        pulse_dones();
        cyc(3);
        checks++;
        if (cnt_es - b_es != 0) begin errors++; $display("FAIL stall_eng_start_early: got %0d want 0", cnt_es - b_es); end
        eng_ready = 1;
        cyc(1);
        checks++;
        if (eng_start !== 1) begin errors++; $display("FAIL stall_eng_start: got %b want 1", eng_start); end
        cyc(1);
        checks++;
        if (eng_clear !== 1) begin errors++; $display("FAIL stall_kept_dones: got %b want 1", eng_clear); end
        cyc(1);
        checks++;
        if (evt !== 1) begin errors++; $display("FAIL stall_evt: got %b want 1", evt); end
        cyc(3);
        checks += 3;
        if (cnt_src - b_src != 1) begin errors++; $display("FAIL busy_trigger_ignored: got %0d starts want 1", cnt_src - b_src); end
        if (cnt_evt - b_evt != 1) begin errors++; $display("FAIL stall_evt_count: got %0d want 1", cnt_evt - b_evt); end
        if (busy !== 0)           begin errors++; $display("FAIL stall_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_clear_and_trigger();
        snap();
        clear = 1; n_iter = 1; trigger = 1;
        cyc(1);
        clear = 0; trigger = 0;
        cyc(3);
        checks += 2;
        if (busy !== 0)           begin errors++; $display("FAIL clear_trigger_busy: got %b want 0", busy); end
        if (cnt_src - b_src != 0) begin errors++; $display("FAIL clear_trigger_start: got %0d want 0", cnt_src - b_src); end
    endtask

    task automatic test_idle_dones();
        int k;
        pulse_dones();
        cyc(1);
        snap(); out_cnt = 4;
        trig(1, 4);
        wait_eng_start("idle_dones_start");
        cyc(5);
        checks += 2;
        if (cnt_ec - b_ec != 0) begin errors++; $display("FAIL idle_dones_ignored: got %0d clears want 0", cnt_ec - b_ec); end
        if (busy !== 1)         begin errors++; $display("FAIL idle_dones_busy: got %b want 1", busy); end
        pulse_dones();
        wait_evt("idle_dones_evt", k);
        cyc(2);
    endtask

    task automatic test_no_progress();
        int k;
        snap(); out_cnt = 4; out_hs = 0;
        trig(1, 4);
        wait_eng_start("noprog_start");
`ifdef MDF_SEQ_WATCHDOG_EN
        k = 0;
        while (!err && k < 100) begin cyc(1); k++; end
        checks++;
        if (k != 16) begin errors++; $display("FAIL watchdog_latency: got %0d want 16", k); end
        wait_evt("watchdog_evt", k);
        checks += 2;
        if (k != 1)             begin errors++; $display("FAIL watchdog_evt_latency: got %0d want 1", k); end
        if (cnt_ec - b_ec != 1) begin errors++; $display("FAIL watchdog_clear: got %0d want 1", cnt_ec - b_ec); end
        cyc(2);
        checks++;
        if (err !== 1) begin errors++; $display("FAIL watchdog_err_sticky: got %b want 1", err); end
`else
        cyc(40);
        checks += 3;
        if (busy !== 1)           begin errors++; $display("FAIL hang_busy: got %b want 1", busy); end
        if (err !== 0)            begin errors++; $display("FAIL hang_err: got %b want 0", err); end
        if (cnt_evt - b_evt != 0) begin errors++; $display("FAIL hang_evt: got %0d want 0", cnt_evt - b_evt); end
        k = 0;
`endif
        clear = 1;
        cyc(1);
        clear = 0;
        checks++;
        if (busy !== 0 || err !== 0) begin errors++; $display("FAIL noprog_clear: got busy=%b err=%b want 0 0", busy, err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_latency();
        test_zero_iter();
        test_multi();
        test_clear_mid_job();
        test_ready_stall();
        test_clear_and_trigger();
        test_idle_dones();
        test_no_progress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
